rk_value_bank: RTL and testbench
================================

Name: rk_value_bank

Overview:
- Parametrised multi-entry storage bank for the RK4 datapath.
- Holds signed fixed-point intermediates (k1..k4, y_n history) for the step-update logic.
- Generalises the single load/clear output register with:
  - addressed writes,
  - two asynchronous read ports,
  - a saturating accumulate mode,
  - a shift-history mode,
  - per-entry valid flags and a sticky overflow flag.

Parameters:
- WIDTH, 32, data word width (signed, Q16.16 in the RK4 datapath).
- DEPTH, 4, number of entries (2..16, need not be a power of two).
- AW, 2, address width; must satisfy 2**AW >= DEPTH.

Ports:
- CLK  in  1  rising-edge clock.
- CLR  in  1  reset, asynchronous, active-high; clock CLK.
- SCLR  in  1  synchronous clear of all entries, valid flags and OVF.
- WE  in  1  write strobe.
- MODE  in  2  write mode: 00 load, 01 accumulate, 10 shift, 11 reserved (no-op).
- WADDR  in  AW  write address (ignored in shift mode).
- WDATA  in  WIDTH  signed write data.
- RADDR_A  in  AW  read port A address.
- RDATA_A  out  WIDTH  entry at RADDR_A, combinational.
- RADDR_B  in  AW  read port B address.
- RDATA_B  out  WIDTH  entry at RADDR_B, combinational.
- VALID  out  DEPTH  per-entry written-since-clear flag.
- OVF  out  1  sticky saturation flag.

Behaviour:
- Reset (CLR high, asynchronous):
  - all entries = 0, VALID = 0, OVF = 0;
  - holds while CLR is high; registers update only on CLK rising edges after CLR deasserts.
- Priority per edge: CLR > SCLR > WE. SCLR has the same effect as CLR but is synchronous; a WE in the same cycle is discarded.
- Load (MODE=00, WE=1):
  - mem[WADDR] <= WDATA;
  - VALID[WADDR] <= 1.
- Accumulate (MODE=01, WE=1):
  - mem[WADDR] <= sat(mem[WADDR] + WDATA);
  - VALID[WADDR] <= 1.
  - The sum is computed at WIDTH+1 bits and then saturated:
    - above 2^(WIDTH-1)-1 -> 0x7FFF_FFFF, set OVF;
    - below -2^(WIDTH-1) -> 0x8000_0000, set OVF.
  - Accumulating into an entry with VALID=0 uses its stored value, which is 0 after a clear.
- Shift (MODE=10, WE=1):
  - mem[i] <= mem[i-1] for i = DEPTH-1 down to 1; mem[0] <= WDATA;
  - VALID shifts identically, with VALID[0] <= 1;
  - the oldest entry is discarded;
  - WADDR is ignored.
- MODE=11 or WE=0: no state change.
- Out-of-range addresses (value >= DEPTH):
  - a write is ignored entirely, including OVF;
  - a read returns 0.
- Read timing:
  - reads are combinational from current state;
  - a write is visible on RDATA_A/B the cycle after the capturing edge;
  - there is no write-through bypass;
  - ports A and B may address the same entry.
- OVF stays set until CLR or SCLR; no other event clears it.
- Arithmetic is purely signed two's complement; no rounding.

Decomposition:
- Shared package rk_pkg holds:
  - the MODE encodings (MODE_LOAD, MODE_ACC, MODE_SHIFT);
  - the Q16.16 constants (FRAC_BITS=16, SAT_MAX, SAT_MIN).
- One sub-module: rk_sat_add, a combinational WIDTH-bit signed add with saturation and an overflow output. It is reused by the RK4 step-update logic.
- Storage and mode control stay in rk_value_bank.

Test Plan:
- Reset/clear:
  - pulse CLR mid-cycle after loading 0x00018000 into entry 2;
  - -> RDATA immediately 0, VALID=0000, without waiting for a clock edge;
  - repeat using SCLR together with WE;
  - -> cleared at the next edge, write dropped.
- Load and dual read:
  - load entries 0..3 with 0x00010000, 0x00020000, 0x00030000, 0x00040000;
  - RADDR_A=1, RADDR_B=3 -> 0x00020000 / 0x00040000;
  - VALID=1111.
- Accumulate with saturation:
  - load 0x7FFF0000 into entry 0, then accumulate 0x00020000;
  - -> 0x7FFFFFFF, OVF=1;
  - accumulate 0xFFFF0000 into entry 1 holding 0x00010000 -> 0, OVF remains 1.
- Negative saturation:
  - entry 2 = 0x80010000, accumulate 0xFFFE0000;
  - -> 0x80000000, OVF=1.
- Shift history (DEPTH=4):
  - shift in 0x00010000, 0x00020000, 0x00030000, 0x00040000, 0x00050000;
  - -> entries 0..3 = 0x00050000, 0x00040000, 0x00030000, 0x00020000;
  - VALID after the first shift = 0001.
- Out-of-range (DEPTH=3, AW=2):
  - write with WADDR=3 -> no state change, OVF unchanged;
  - RADDR_A=3 -> RDATA_A=0.

Source files
------------

// File: rtl/rk_pkg.sv
// rtl/rk_pkg.sv - shared RK4 datapath encodings and Q16.16 constants
package rk_pkg;

   // Write-mode encodings for the value bank; 2'b11 is reserved and acts as a no-op.
   typedef enum logic [1:0] {
      MODE_LOAD  = 2'b00,
      MODE_ACC   = 2'b01,
      MODE_SHIFT = 2'b10,
      MODE_RSVD  = 2'b11
   } rk_mode_e;

   // Q16.16 fixed-point format used by the RK4 datapath.
   localparam int                 FRAC_BITS = 16;
   localparam logic signed [31:0] SAT_MAX   = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] SAT_MIN   = 32'sh8000_0000;

endpackage

// File: rtl/rk_sat_add.sv
// rtl/rk_sat_add.sv - combinational signed add with saturation
//
// Purpose: WIDTH-bit two's complement add, clamped to the signed range.
// Ports:
//   a_i, b_i  in   WIDTH  signed operands
//   sum_o     out  WIDTH  saturated sum
//   ovf_o     out  1      high when the true sum fell outside the range
module rk_sat_add #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] a_i,
   input  logic signed [WIDTH-1:0] b_i,
   output logic signed [WIDTH-1:0] sum_o,
   output logic                    ovf_o
);

   logic signed [WIDTH:0] sum_ext;

   // One guard bit: the sum overflowed iff the guard and MSB disagree,
   // and the guard bit then gives the true sign of the result.
   assign sum_ext = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
   assign ovf_o   = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];

   always_comb begin
      sum_o = sum_ext[WIDTH-1:0];
      if (ovf_o) begin
         if (sum_ext[WIDTH]) sum_o = {1'b1, {(WIDTH-1){1'b0}}};
         else                sum_o = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/rk_value_bank.sv
// rtl/rk_value_bank.sv - multi-entry signed storage bank for RK4 intermediates
//
// Purpose: addressed load / saturating accumulate / shift-history storage
// with two combinational read ports, per-entry valid flags and sticky OVF.
// Ports:
//   CLK, CLR          clock, asynchronous active-high reset
//   SCLR              synchronous clear (beats WE)
//   WE, MODE, WADDR   write strobe, write mode, write address
//   WDATA             signed write data
//   RADDR_A/RDATA_A   read port A (combinational, 0 when out of range)
//   RADDR_B/RDATA_B   read port B (combinational, 0 when out of range)
//   VALID             per-entry written-since-clear flags
//   OVF               sticky saturation flag
module rk_value_bank
   import rk_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                    CLK,
   input  logic                    CLR,
   input  logic                    SCLR,
   input  logic                    WE,
   input  logic [1:0]              MODE,
   input  logic [AW-1:0]           WADDR,
   input  logic signed [WIDTH-1:0] WDATA,
   input  logic [AW-1:0]           RADDR_A,
   output logic signed [WIDTH-1:0] RDATA_A,
   input  logic [AW-1:0]           RADDR_B,
   output logic signed [WIDTH-1:0] RDATA_B,
   output logic [DEPTH-1:0]        VALID,
   output logic                    OVF
);

   logic signed [WIDTH-1:0] mem_q [DEPTH];
   logic signed [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]        valid_q, valid_d;
   logic                    ovf_q, ovf_d;

   logic [DEPTH-1:0]        wsel;
   logic signed [WIDTH-1:0] acc_old, acc_sum;
   logic                    acc_ovf;

   // Read muxes match only real entries, so addresses >= DEPTH fall through to 0.
   always_comb begin
      RDATA_A = '0;
      RDATA_B = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (RADDR_A == AW'(i)) RDATA_A = mem_q[i];
         if (RADDR_B == AW'(i)) RDATA_B = mem_q[i];
      end
   end

   // One-hot write select; all-zero for an out-of-range address, which
   // suppresses the write and the OVF update together.
   always_comb begin
      wsel    = '0;
      acc_old = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (WADDR == AW'(i)) begin
            wsel[i] = 1'b1;
            acc_old = mem_q[i];
         end
      end
   end

   rk_sat_add #(.WIDTH(WIDTH)) u_sat (
      .a_i   (acc_old),
      .b_i   (WDATA),
      .sum_o (acc_sum),
      .ovf_o (acc_ovf)
   );

   always_comb begin
      mem_d   = mem_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (SCLR) begin
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
         valid_d = '0;
         ovf_d   = 1'b0;
      end else if (WE) begin
         case (MODE)
            MODE_LOAD: begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (wsel[i]) begin
                     mem_d[i]   = WDATA;
                     valid_d[i] = 1'b1;
                  end
               end
            end
            MODE_ACC: begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (wsel[i]) begin
                     mem_d[i]   = acc_sum;
                     valid_d[i] = 1'b1;
                  end
               end
               if ((|wsel) && acc_ovf) ovf_d = 1'b1;
            end
            MODE_SHIFT: begin
               for (int i = DEPTH - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
               mem_d[0] = WDATA;
               valid_d  = {valid_q[DEPTH-2:0], 1'b1};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         valid_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign VALID = valid_q;
   assign OVF   = ovf_q;

endmodule

// File: tb/tb_rk_value_bank.sv
// tb/tb_rk_value_bank.sv - directed self-checking bench for rk_value_bank
module tb_rk_value_bank;

   logic        CLK = 1'b0;
   logic        CLR = 1'b1;
   logic        SCLR = 1'b0;
   logic        we0 = 1'b0;
   logic        we1 = 1'b0;
   logic [1:0]  MODE = 2'b00;
   logic [1:0]  WADDR = '0;
   logic [31:0] WDATA = '0;
   logic [1:0]  RADDR_A = '0;
   logic [1:0]  RADDR_B = '0;

   logic [31:0] rda0, rdb0, rda1, rdb1;
   logic [3:0]  valid0;
   logic [2:0]  valid1;
   logic        ovf0, ovf1;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   rk_value_bank #(.WIDTH(32), .DEPTH(4), .AW(2)) u0 (
      .CLK(CLK), .CLR(CLR), .SCLR(SCLR), .WE(we0), .MODE(MODE), .WADDR(WADDR),
      .WDATA(WDATA), .RADDR_A(RADDR_A), .RDATA_A(rda0), .RADDR_B(RADDR_B),
      .RDATA_B(rdb0), .VALID(valid0), .OVF(ovf0)
   );

   rk_value_bank #(.WIDTH(32), .DEPTH(3), .AW(2)) u1 (
      .CLK(CLK), .CLR(CLR), .SCLR(SCLR), .WE(we1), .MODE(MODE), .WADDR(WADDR),
      .WDATA(WDATA), .RADDR_A(RADDR_A), .RDATA_A(rda1), .RADDR_B(RADDR_B),
      .RDATA_B(rdb1), .VALID(valid1), .OVF(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one write on the following rising edge; sel=1 targets the DEPTH=3 bank.
   task automatic wr(input logic [1:0] m, input logic [1:0] a, input logic [31:0] d,
                     input bit sel);
      @(negedge CLK);
      MODE  = m;
      WADDR = a;
      WDATA = d;
      we0   = !sel;
      we1   = sel;
      @(posedge CLK);
      #1;
      we0 = 1'b0;
      we1 = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [1:0] b);
      RADDR_A = a;
      RADDR_B = b;
      #1;
   endtask

   task automatic sclr_pulse();
      @(negedge CLK);
      SCLR = 1'b1;
      @(posedge CLK);
      #1;
      SCLR = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      rd(2'd0, 2'd3);
      chk("rst_rda", rda0, 32'h0);
      chk("rst_valid", {28'h0, valid0}, 32'h0);
      chk("rst_ovf", {31'h0, ovf0}, 32'h0);
      CLR = 1'b0;

      // Asynchronous CLR mid-cycle
      wr(2'b00, 2'd2, 32'h0001_8000, 1'b0);
      rd(2'd2, 2'd2);
      chk("load_e2", rda0, 32'h0001_8000);
      chk("load_e2_valid", {28'h0, valid0}, 32'h4);
      #2;
      CLR = 1'b1;
      #1;
      chk("aclr_rda", rda0, 32'h0);
      chk("aclr_valid", {28'h0, valid0}, 32'h0);
      CLR = 1'b0;

      // SCLR beats a same-cycle WE
      wr(2'b00, 2'd2, 32'h0001_8000, 1'b0);
      @(negedge CLK);
      SCLR  = 1'b1;
      MODE  = 2'b00;
      WADDR = 2'd1;
      WDATA = 32'h0000_1234;
      we0   = 1'b1;
      rd(2'd2, 2'd1);
      chk("sclr_pre_edge", rda0, 32'h0001_8000);
      @(posedge CLK);
      #1;
      SCLR = 1'b0;
      we0  = 1'b0;
      chk("sclr_rda", rda0, 32'h0);
      chk("sclr_drop_wr", rdb0, 32'h0);
      chk("sclr_valid", {28'h0, valid0}, 32'h0);

      // Load and dual read
      wr(2'b00, 2'd0, 32'h0001_0000, 1'b0);
      wr(2'b00, 2'd1, 32'h0002_0000, 1'b0);
      wr(2'b00, 2'd2, 32'h0003_0000, 1'b0);
      wr(2'b00, 2'd3, 32'h0004_0000, 1'b0);
      rd(2'd1, 2'd3);
      chk("dual_a", rda0, 32'h0002_0000);
      chk("dual_b", rdb0, 32'h0004_0000);
      chk("load_valid", {28'h0, valid0}, 32'hF);
      rd(2'd2, 2'd2);
      chk("same_addr_a", rda0, 32'h0003_0000);
      chk("same_addr_b", rdb0, 32'h0003_0000);

      // No write-through: old value visible until the capturing edge
      @(negedge CLK);
      MODE = 2'b00; WADDR = 2'd0; WDATA = 32'h0000_00AA; we0 = 1'b1;
      rd(2'd0, 2'd0);
      chk("no_bypass", rda0, 32'h0001_0000);
      @(posedge CLK);
      #1;
      we0 = 1'b0;
      chk("after_edge", rda0, 32'h0000_00AA);

      // Positive saturation
      wr(2'b00, 2'd0, 32'h7FFF_0000, 1'b0);
      wr(2'b01, 2'd0, 32'h0002_0000, 1'b0);
      rd(2'd0, 2'd1);
      chk("pos_sat", rda0, 32'h7FFF_FFFF);
      chk("pos_sat_ovf", {31'h0, ovf0}, 32'h1);
      wr(2'b00, 2'd1, 32'h0001_0000, 1'b0);
      wr(2'b01, 2'd1, 32'hFFFF_0000, 1'b0);
      rd(2'd1, 2'd0);
      chk("acc_to_zero", rda0, 32'h0);
      chk("ovf_sticky", {31'h0, ovf0}, 32'h1);

      // SCLR clears OVF; accumulate into cleared entry, reserved mode is no-op
      sclr_pulse();
      chk("sclr_ovf", {31'h0, ovf0}, 32'h0);
      wr(2'b01, 2'd3, 32'h0001_0000, 1'b0);
      rd(2'd3, 2'd0);
      chk("acc_from_clear", rda0, 32'h0001_0000);
      chk("acc_valid", {28'h0, valid0}, 32'h8);
      chk("acc_no_ovf", {31'h0, ovf0}, 32'h0);
      wr(2'b11, 2'd3, 32'h5555_5555, 1'b0);
      rd(2'd3, 2'd0);
      chk("mode11_noop", rda0, 32'h0001_0000);

      // Negative saturation
      wr(2'b00, 2'd2, 32'h8001_0000, 1'b0);
      wr(2'b01, 2'd2, 32'hFFFE_0000, 1'b0);
      rd(2'd2, 2'd0);
      chk("neg_sat", rda0, 32'h8000_0000);
      chk("neg_sat_ovf", {31'h0, ovf0}, 32'h1);

      // Shift history
      sclr_pulse();
      wr(2'b10, 2'd3, 32'h0001_0000, 1'b0);
      chk("shift1_valid", {28'h0, valid0}, 32'h1);
      rd(2'd0, 2'd1);
      chk("shift1_e0", rda0, 32'h0001_0000);
      wr(2'b10, 2'd1, 32'h0002_0000, 1'b0);
      wr(2'b10, 2'd0, 32'h0003_0000, 1'b0);
      wr(2'b10, 2'd2, 32'h0004_0000, 1'b0);
      wr(2'b10, 2'd3, 32'h0005_0000, 1'b0);
      rd(2'd0, 2'd1);
      chk("shift_e0", rda0, 32'h0005_0000);
      chk("shift_e1", rdb0, 32'h0004_0000);
      rd(2'd2, 2'd3);
      chk("shift_e2", rda0, 32'h0003_0000);
      chk("shift_e3", rdb0, 32'h0002_0000);
      chk("shift_valid", {28'h0, valid0}, 32'hF);

      // Out-of-range on the DEPTH=3 bank
      wr(2'b00, 2'd2, 32'h7FFF_FFFF, 1'b1);
      wr(2'b01, 2'd3, 32'h7FFF_FFFF, 1'b1);
      wr(2'b00, 2'd3, 32'h1111_1111, 1'b1);
      rd(2'd3, 2'd2);
      chk("oor_read", rda1, 32'h0);
      chk("oor_e2", rdb1, 32'h7FFF_FFFF);
      chk("oor_ovf", {31'h0, ovf1}, 32'h0);
      chk("oor_valid", {29'h0, valid1}, 32'h4);
      wr(2'b01, 2'd2, 32'h0000_0001, 1'b1);
      rd(2'd3, 2'd2);
      chk("d3_sat", rdb1, 32'h7FFF_FFFF);
      chk("d3_ovf", {31'h0, ovf1}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
